// File: rtl/wb_commit_queue.sv
// Dual-issue in-order writeback buffer feeding the Register_file write ports.
// Retires up to two entries per cycle. When a commit pair writes the same rd,
// port 1 is suppressed so the younger result is the one that lands.
module wb_commit_queue #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PTR_W = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        hold,
  input  logic        in_valid_a,
  input  logic [4:0]  in_rd_a,
  input  logic [31:0] in_data_a,
  input  logic [3:0]  in_we_a,
  input  logic        in_valid_b,
  input  logic [4:0]  in_rd_b,
  input  logic [31:0] in_data_b,
  input  logic [3:0]  in_we_b,
  output logic        in_ready,
  output logic [4:0]  rd1,
  output logic [31:0] wb_data1,
  output logic [3:0]  wb_we1,
  output logic [4:0]  rd2,
  output logic [31:0] wb_data2,
  output logic [3:0]  wb_we2,
  output logic [PTR_W:0] count,
  output logic        empty,
  output logic        overflow
);

  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam logic [3:0]  WE_REG = 4'd2;

  logic [4:0]  rd_q   [DEPTH];
  logic [31:0] data_q [DEPTH];
  logic [3:0]  we_q   [DEPTH];

  logic [PTR_W-1:0] head, tail, head_p1, tail_p1;
  logic [1:0]       push_cnt, pop_cnt;
  logic             drop;
  logic             collide;
  logic [CNT_W-1:0] count_next;

  assign head_p1 = head + PTR_W'(1);
  assign tail_p1 = tail + PTR_W'(1);

  // Push/pop amounts, drop detection and same-rd pair detection
  always_comb begin
    push_cnt   = 2'd0;
    pop_cnt    = 2'd0;
    drop       = 1'b0;
    collide    = 1'b0;
    count_next = count;
    if (!flush) begin
      if (in_ready) begin
        push_cnt = 2'(in_valid_a) + 2'(in_valid_b);
      end else begin
        drop = in_valid_a | in_valid_b;
      end
      if (!hold) begin
        pop_cnt = (count >= CNT_W'(2)) ? 2'd2 : 2'(count);
      end
    end
    collide = (pop_cnt == 2'd2) && (we_q[head] == WE_REG) &&
              (we_q[head_p1] == WE_REG) && (rd_q[head] == rd_q[head_p1]);
    count_next = count + CNT_W'(push_cnt) - CNT_W'(pop_cnt);
  end

  // Entry storage; a lone valid input always goes to tail
  always_ff @(posedge clk) begin
    if (push_cnt != 2'd0) begin
      rd_q[tail]   <= in_valid_a ? in_rd_a   : in_rd_b;
      data_q[tail] <= in_valid_a ? in_data_a : in_data_b;
      we_q[tail]   <= in_valid_a ? in_we_a   : in_we_b;
    end
    if (push_cnt == 2'd2) begin
      rd_q[tail_p1]   <= in_rd_b;
      data_q[tail_p1] <= in_data_b;
      we_q[tail_p1]   <= in_we_b;
    end
  end

  // Pointers, occupancy flags and registered write-port outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      in_ready <= 1'b1;
      empty    <= 1'b1;
      overflow <= 1'b0;
      rd1      <= '0;
      wb_data1 <= '0;
      wb_we1   <= 4'd0;
      rd2      <= '0;
      wb_data2 <= '0;
      wb_we2   <= 4'd0;
    end else if (flush) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      in_ready <= 1'b1;
      empty    <= 1'b1;
      wb_we1   <= 4'd0;
      wb_we2   <= 4'd0;
    end else begin
      head     <= head + PTR_W'(pop_cnt);
      tail     <= tail + PTR_W'(push_cnt);
      count    <= count_next;
      in_ready <= (count_next <= CNT_W'(DEPTH - 2));
      empty    <= (count_next == '0);
      if (drop) begin
        overflow <= 1'b1;
      end
      if (pop_cnt != 2'd0) begin
        rd1      <= rd_q[head];
        wb_data1 <= data_q[head];
        wb_we1   <= collide ? 4'd0 : we_q[head];
      end else begin
        wb_we1   <= 4'd0;
      end
      if (pop_cnt == 2'd2) begin
        rd2      <= rd_q[head_p1];
        wb_data2 <= data_q[head_p1];
        wb_we2   <= we_q[head_p1];
      end else begin
        wb_we2   <= 4'd0;
      end
    end
  end

endmodule

// File: tb/tb_wb_commit_queue.sv
// Directed bench for wb_commit_queue with a small Register_file model.
module tb_wb_commit_queue;

  logic        clk = 1'b0;
  logic        rst_n, flush, hold;
  logic        in_valid_a, in_valid_b;
  logic [4:0]  in_rd_a, in_rd_b;
  logic [31:0] in_data_a, in_data_b;
  logic [3:0]  in_we_a, in_we_b;
  logic        in_ready, empty, overflow;
  logic [4:0]  rd1, rd2;
  logic [31:0] wb_data1, wb_data2;
  logic [3:0]  wb_we1, wb_we2;
  logic [3:0]  count;

  int errors = 0;
  int checks = 0;
  logic [31:0] rf [32];

  always #5 clk = ~clk;

  wb_commit_queue #(.DEPTH(8), .PTR_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .hold(hold),
    .in_valid_a(in_valid_a), .in_rd_a(in_rd_a), .in_data_a(in_data_a), .in_we_a(in_we_a),
    .in_valid_b(in_valid_b), .in_rd_b(in_rd_b), .in_data_b(in_data_b), .in_we_b(in_we_b),
    .in_ready(in_ready),
    .rd1(rd1), .wb_data1(wb_data1), .wb_we1(wb_we1),
    .rd2(rd2), .wb_data2(wb_data2), .wb_we2(wb_we2),
    .count(count), .empty(empty), .overflow(overflow)
  );

  // Register_file model: port 1 has priority on a same-rd write
  always @(posedge clk) begin
    if (wb_we2 == 4'd2) rf[rd2] <= wb_data2;
    if (wb_we1 == 4'd2) rf[rd1] <= wb_data1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid_a = 1'b0; in_valid_b = 1'b0;
  endtask

  task automatic set_a(input logic [4:0] rd, input logic [31:0] d, input logic [3:0] we);
    in_valid_a = 1'b1; in_rd_a = rd; in_data_a = d; in_we_a = we;
  endtask

  task automatic set_b(input logic [4:0] rd, input logic [31:0] d, input logic [3:0] we);
    in_valid_b = 1'b1; in_rd_b = rd; in_data_b = d; in_we_b = we;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_a(5'd1, 32'h1, 4'd2);
    set_b(5'd2, 32'h2, 4'd2);
    step();
    step();
    idle();
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = '0;
    flush = 1'b0; hold = 1'b0;
    in_rd_a = '0; in_data_a = '0; in_we_a = '0;
    in_rd_b = '0; in_data_b = '0; in_we_b = '0;
    idle();

    // Reset with active inputs
    do_reset();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_we1", 32'(wb_we1), 32'd0);
    chk("rst_we2", 32'(wb_we2), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_rd1", 32'(rd1), 32'd0);
    chk("rst_data2", wb_data2, 32'd0);

    // Single pass
    set_a(5'd5, 32'hDEADBEEF, 4'd2);
    step();
    idle();
    chk("single_cnt0", 32'(count), 32'd1);
    chk("single_we1_early", 32'(wb_we1), 32'd0);
    step();
    chk("single_rd1", 32'(rd1), 32'd5);
    chk("single_data1", wb_data1, 32'hDEADBEEF);
    chk("single_we1", 32'(wb_we1), 32'd2);
    chk("single_we2", 32'(wb_we2), 32'd0);
    chk("single_cnt1", 32'(count), 32'd0);
    chk("single_empty", 32'(empty), 32'd1);
    step();
    chk("single_rf5", rf[5], 32'hDEADBEEF);
    chk("empty_pop_we1", 32'(wb_we1), 32'd0);
    chk("hold_rd1", 32'(rd1), 32'd5);

    // Same-rd collision
    set_a(5'd7, 32'd1, 4'd2);
    set_b(5'd7, 32'd2, 4'd2);
    step();
    idle();
    chk("coll_cnt", 32'(count), 32'd2);
    step();
    chk("coll_we1", 32'(wb_we1), 32'd0);
    chk("coll_rd2", 32'(rd2), 32'd7);
    chk("coll_data2", wb_data2, 32'd2);
    chk("coll_we2", 32'(wb_we2), 32'd2);
    step();
    chk("coll_rf7", rf[7], 32'd2);

    // Distinct-rd pair with a non-write code
    set_a(5'd3, 32'h11, 4'd2);
    set_b(5'd4, 32'h22, 4'd1);
    step();
    idle();
    step();
    chk("pair_rd1", 32'(rd1), 32'd3);
    chk("pair_data1", wb_data1, 32'h11);
    chk("pair_we1", 32'(wb_we1), 32'd2);
    chk("pair_rd2", 32'(rd2), 32'd4);
    chk("pair_data2", wb_data2, 32'h22);
    chk("pair_we2", 32'(wb_we2), 32'd1);

    // Fill with hold, overflow, then drain across the pointer wrap
    hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_a(5'(8 + 2 * i), 32'h100 + 32'(2 * i), 4'd2);
      set_b(5'(9 + 2 * i), 32'h101 + 32'(2 * i), 4'd2);
      step();
      chk("fill_we1", 32'(wb_we1), 32'd0);
    end
    chk("full_cnt", 32'(count), 32'd8);
    chk("full_ready", 32'(in_ready), 32'd0);
    set_a(5'd30, 32'hBAD0, 4'd2);
    set_b(5'd31, 32'hBAD1, 4'd2);
    step();
    idle();
    chk("drop_ovf", 32'(overflow), 32'd1);
    chk("drop_cnt", 32'(count), 32'd8);
    hold = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("drain_rd1", 32'(rd1), 32'(8 + 2 * k));
      chk("drain_data1", wb_data1, 32'h100 + 32'(2 * k));
      chk("drain_we1", 32'(wb_we1), 32'd2);
      chk("drain_rd2", 32'(rd2), 32'(9 + 2 * k));
      chk("drain_data2", wb_data2, 32'h101 + 32'(2 * k));
      chk("drain_we2", 32'(wb_we2), 32'd2);
      chk("drain_cnt", 32'(count), 32'(6 - 2 * k));
    end
    chk("drain_empty", 32'(empty), 32'd1);
    chk("drain_ready", 32'(in_ready), 32'd1);

    // Flush with 6 queued and a valid pair present
    do_reset();
    chk("rst2_ovf", 32'(overflow), 32'd0);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_a(5'(2 * i + 1), 32'h200 + 32'(i), 4'd2);
      set_b(5'(2 * i + 2), 32'h300 + 32'(i), 4'd2);
      step();
    end
    chk("six_cnt", 32'(count), 32'd6);
    chk("six_ready", 32'(in_ready), 32'd1);
    hold = 1'b0;
    flush = 1'b1;
    set_a(5'd9, 32'h999, 4'd2);
    set_b(5'd10, 32'hAAA, 4'd2);
    step();
    flush = 1'b0;
    idle();
    chk("flush_cnt", 32'(count), 32'd0);
    chk("flush_we1", 32'(wb_we1), 32'd0);
    chk("flush_we2", 32'(wb_we2), 32'd0);
    chk("flush_ovf", 32'(overflow), 32'd0);
    chk("flush_empty", 32'(empty), 32'd1);
    step();
    chk("flush_nostore_we1", 32'(wb_we1), 32'd0);
    chk("flush_nostore_cnt", 32'(count), 32'd0);

    // Steady pair stream with concurrent commit
    for (int i = 0; i < 20; i++) begin
      set_a(5'(2 * (i % 16)), 32'h1000 + 32'(2 * i), 4'd2);
      set_b(5'(2 * (i % 16) + 1), 32'h1001 + 32'(2 * i), 4'd2);
      step();
      chk("stream_cnt", 32'(count), 32'd2);
      if (i > 0) begin
        chk("stream_rd1", 32'(rd1), 32'(2 * ((i - 1) % 16)));
        chk("stream_data1", wb_data1, 32'h1000 + 32'(2 * (i - 1)));
        chk("stream_we1", 32'(wb_we1), 32'd2);
        chk("stream_data2", wb_data2, 32'h1001 + 32'(2 * (i - 1)));
        chk("stream_we2", 32'(wb_we2), 32'd2);
      end
    end
    idle();
    step();
    chk("stream_last_data2", wb_data2, 32'h1001 + 32'd38);
    chk("stream_end_cnt", 32'(count), 32'd0);
    chk("stream_ovf", 32'(overflow), 32'd0);

    // DEPTH-1 occupancy refuses a pair
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_a(5'd1, 32'(i), 4'd2);
      set_b(5'd2, 32'(i), 4'd2);
      step();
    end
    in_valid_b = 1'b0;
    set_a(5'd3, 32'h7, 4'd2);
    step();
    chk("seven_cnt", 32'(count), 32'd7);
    chk("seven_ready", 32'(in_ready), 32'd0);
    set_b(5'd4, 32'h8, 4'd2);
    step();
    idle();
    chk("seven_drop_cnt", 32'(count), 32'd7);
    chk("seven_drop_ovf", 32'(overflow), 32'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    hold = 1'b0;
    chk("final_cnt", 32'(count), 32'd0);
    chk("final_ready", 32'(in_ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
